mux_rr_stream: RTL

//  Parametrised N-channel, W-bit registered stream multiplexer; successor to the 2:1 32-bit datapath mux.

---
 rtl/mux_rr_stream_if.sv | 33 +++
 rtl/mux_rr_stream.sv | 95 +++++++++
 2 files changed

// File: rtl/mux_rr_stream_if.sv
// ============================================================================
// mux_rr_stream_if : valid/ready bundle between the stream mux and its users
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mux_rr_stream_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     mode;
  logic [NUM_CH*WIDTH-1:0]  in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/mux_rr_stream.sv
// ============================================================================
// mux_rr_stream : N-channel registered stream mux, round-robin / fixed priority
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_rr_stream #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  wire              clk,
  input  wire              rst_n,
  mux_rr_stream_if.slave   bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic             load_en;
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] scan_idx;
  logic             xfer;

  assign load_en = !valid_q || bus.out_ready;

  // Loops run from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (bus.mode) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (bus.in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        scan_idx = SEL_W'((int'(ptr_q) + k) % NUM_CH);
        if (bus.in_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  assign xfer = load_en && grant_any;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.in_ready[i] = rst_n && xfer && (grant_idx == SEL_W'(i));
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q && !bus.out_ready;
    if (xfer) begin
      ptr_d   = grant_idx;
      sel_d   = grant_idx;
      data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= SEL_W'(NUM_CH - 1);
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

endmodule

`default_nettype wire
